bus_mem_responder: RTL

//  Bus-slave memory on the shared 8-bit tri-state CPU data bus. It is the

---
 rtl/bus_mem_responder.sv | 85 ++++++++
 1 files changed

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: bus-slave memory with wait states and ready handshake; AUTO_INC_EN enables post-access address increment
module bus_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [7:0]        bus,
  input  logic              ARin,
  input  logic              Min,
  input  logic              Mout,
  output logic              ready,
  output logic              err,
  output logic [ADDR_W-1:0] addr_dbg
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] addr;
  logic [7:0] wdata, rdata;
  logic is_rd, multi, go, in_range;
  logic [IW-1:0] idx;
  logic [7:0] mem [DEPTH];
  assign multi    = (ARin & Min) | (ARin & Mout) | (Min & Mout);
  assign go       = state == IDLE && !multi && (Min || Mout);
  assign in_range = {1'b0, addr} < LIM;
  assign idx      = IW'(addr);
  assign ready    = state != BUSY;
  assign addr_dbg = addr;
  assign bus      = (state == DONE && is_rd) ? rdata : 8'hzz;
`ifdef AUTO_INC_EN
  logic [ADDR_W:0] inc, inc_w;
  assign inc   = {1'b0, addr} + (ADDR_W+1)'(1);
  assign inc_w = inc >= LIM ? inc - LIM : inc;
`endif
  // next-state and wait counter
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: if (go) begin
        state_nx = WC == 4'd0 ? DONE : BUSY;
        cnt_nx   = WC;
      end
      BUSY: begin
        cnt_nx   = cnt - 4'd1;
        state_nx = cnt == 4'd1 ? DONE : BUSY;
      end
      default: state_nx = IDLE;
    endcase
  end
  // control registers, address and captured data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      err   <= 1'b0;
      is_rd <= 1'b0;
      wdata <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= state == IDLE && multi;
      if (state == IDLE && !multi && ARin) addr <= bus[ADDR_W-1:0];
      if (go) begin
        is_rd <= Mout;
        wdata <= bus;
        rdata <= in_range ? mem[idx] : 8'h00;
      end
`ifdef AUTO_INC_EN
      if (state == DONE) addr <= inc_w[ADDR_W-1:0];
`endif
    end
  end
  // storage array, written on the DONE exit edge; out-of-range writes dropped
  always_ff @(posedge clk) begin
    if (rst && state == DONE && !is_rd && in_range) mem[idx] <= wdata;
  end
endmodule
